// File: rtl/grid_pkg.sv
// Shared types and defaults for the tile-grid frame-diff scanner.
// Object codes: 0 is an empty cell; flag i maps to code i+1.
package grid_pkg;
  localparam int DEF_COLS = 16;
  localparam int DEF_ROWS = 12;
  localparam int BLANK    = 0;

  // Codes for the default 4-flag configuration (flag index 0..3 -> code 1..4).
  typedef enum logic [2:0] {
    OBJ_BLANK  = 3'd0,
    OBJ_BORDER = 3'd1,
    OBJ_HEAD   = 3'd2,
    OBJ_BODY   = 3'd3,
    OBJ_APPLE  = 3'd4
  } grid_obj_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } scan_state_e;
endpackage

// File: rtl/grid_diff_scanner_if.sv
// Changed-cell record stream from the scanner to the tile renderer (valid/ready).
interface grid_diff_scanner_if #(
  parameter int XW     = 4,
  parameter int YW     = 4,
  parameter int CODE_W = 3
);
  logic              out_valid;
  logic              out_ready;
  logic [XW-1:0]     out_x;
  logic [YW-1:0]     out_y;
  logic [CODE_W-1:0] out_code;

  modport master (output out_valid, out_x, out_y, out_code, input out_ready);
  modport slave  (input out_valid, out_x, out_y, out_code, output out_ready);
endinterface

// File: rtl/grid_frame_mem.sv
// Shadow frame register file: async read, single write port, synchronous bulk clear.
// Clear wins over a same-cycle write; reset and clear both restore every cell to BLANK.
module grid_frame_mem
  import grid_pkg::*;
#(
  parameter int CELLS  = 192,
  parameter int CODE_W = 3,
  localparam int AW    = $clog2(CELLS)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              clear_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [CODE_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [CODE_W-1:0] rdata_o
);
  logic [CODE_W-1:0] mem_q [CELLS];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < CELLS; i++) mem_q[i] <= CODE_W'(BLANK);
    end else if (clear_i) begin
      for (int i = 0; i < CELLS; i++) mem_q[i] <= CODE_W'(BLANK);
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/grid_diff_scanner.sv
// Raster-scans the shadow frame once per start, emitting changed (or all, in redraw) cells.
// The cursor advances only when the output register can take a new record.
module grid_diff_scanner
  import grid_pkg::*;
#(
  parameter int  COLS    = DEF_COLS,
  parameter int  ROWS    = DEF_ROWS,
  parameter int  NUM_OBJ = 4,
  localparam int CODE_W  = $clog2(NUM_OBJ + 1),
  localparam int XW      = $clog2(COLS),
  localparam int YW      = $clog2(ROWS),
  localparam int CW      = $clog2(COLS * ROWS + 1),
  localparam int CELLS   = COLS * ROWS,
  localparam int AW      = $clog2(CELLS)
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
  input  logic               force_redraw,
  input  logic               clear,
  input  logic [NUM_OBJ-1:0] obj_present,
  output logic [XW-1:0]      cur_x,
  output logic [YW-1:0]      cur_y,
  output logic               busy,
  output logic               frame_done,
  output logic [CW-1:0]      diff_count,
  grid_diff_scanner_if.master out_if
);
  scan_state_e       state_q;
  logic [XW-1:0]     cur_x_q;
  logic [YW-1:0]     cur_y_q;
  logic [AW-1:0]     idx_q;
  logic              redraw_q, busy_q, done_q;
  logic [CW-1:0]     cnt_q, cnt_d, diff_q;
  logic              ov_q;
  logic [XW-1:0]     ox_q;
  logic [YW-1:0]     oy_q;
  logic [CODE_W-1:0] oc_q;

  logic [CODE_W-1:0] new_code, stored;
  logic              step, scan_step, emit, last_cell, row_end;

  // Lowest-index flag wins, so scan from the top down and let lower indices overwrite.
  always_comb begin
    new_code = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (obj_present[i]) new_code = CODE_W'(i + 1);
    end
  end

  assign step      = !ov_q || out_if.out_ready;
  assign scan_step = (state_q == S_SCAN) && step;
  assign emit      = scan_step && ((new_code != stored) || redraw_q);
  assign row_end   = (cur_x_q == XW'(COLS - 1));
  assign last_cell = row_end && (cur_y_q == YW'(ROWS - 1));
  assign cnt_d     = emit ? cnt_q + CW'(1) : cnt_q;

  grid_frame_mem #(.CELLS(CELLS), .CODE_W(CODE_W)) u_frame (
    .clk     (clk),
    .nrst    (nrst),
    .clear_i ((state_q == S_IDLE) && clear),
    .we_i    (scan_step),
    .waddr_i (idx_q),
    .wdata_i (new_code),
    .raddr_i (idx_q),
    .rdata_o (stored)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= S_IDLE;
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      idx_q    <= '0;
      redraw_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !clear) begin
            redraw_q <= force_redraw;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (step) begin
            cnt_q <= cnt_d;
            if (last_cell) begin
              // Cursor parks at the origin so IDLE already presents cell (0,0).
              cur_x_q <= '0;
              cur_y_q <= '0;
              idx_q   <= '0;
              done_q  <= 1'b1;
              diff_q  <= cnt_d;
              state_q <= S_DONE;
            end else if (row_end) begin
              cur_x_q <= '0;
              cur_y_q <= cur_y_q + YW'(1);
              idx_q   <= idx_q + AW'(1);
            end else begin
              cur_x_q <= cur_x_q + XW'(1);
              idx_q   <= idx_q + AW'(1);
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A record loading on an accepting cycle replaces the old one without a bubble.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ov_q <= 1'b0;
      ox_q <= '0;
      oy_q <= '0;
      oc_q <= '0;
    end else if (emit) begin
      ov_q <= 1'b1;
      ox_q <= cur_x_q;
      oy_q <= cur_y_q;
      oc_q <= new_code;
    end else if (out_if.out_ready) begin
      ov_q <= 1'b0;
    end
  end

  assign cur_x           = cur_x_q;
  assign cur_y           = cur_y_q;
  assign busy            = busy_q;
  assign frame_done      = done_q;
  assign diff_count      = diff_q;
  assign out_if.out_valid = ov_q;
  assign out_if.out_x    = ox_q;
  assign out_if.out_y    = oy_q;
  assign out_if.out_code = oc_q;
endmodule

// File: doc/grid_diff_scanner.md
# grid_diff_scanner

Parametrised frame-diff engine for tile-based graphics. It holds a COLS x ROWS shadow frame of object codes and raster-scans the grid once per `start`. For each cell it compares the upstream object flags against the stored code and emits only the changed cells, or every cell in redraw mode, over a valid/ready stream to the tile renderer. It also pulses `frame_done` at the end of each pass and reports a per-frame change count.

## Interface
- `COLS`, default 16: grid columns; must be ≥ 2.
- `ROWS`, default 12: grid rows; must be ≥ 2.
- `NUM_OBJ`, default 4: number of object flags. Derived: `CODE_W = $clog2(NUM_OBJ+1)`, `XW = $clog2(COLS)`, `YW = $clog2(ROWS)`, `CW = $clog2(COLS*ROWS+1)`.
- `clk`  in  1: clock.
- `nrst`  in  1: reset, asynchronous, active-low.
- `start`  in  1: begin one scan pass; only honoured in IDLE.
- `force_redraw`  in  1: sampled with `start`; when set, every cell of that pass is emitted.
- `clear`  in  1: sets the whole shadow frame to BLANK; only honoured in IDLE.
- `obj_present`  in  NUM_OBJ: object flags for the cell at (`cur_x`, `cur_y`); combinational from upstream.
- `cur_x` / `cur_y`  out  XW / YW: scan cursor.
- `out_valid`  out  1: changed-cell record available.
- `out_ready`  in  1: downstream accept.
- `out_x` / `out_y` / `out_code`  out  XW / YW / CODE_W: cell coordinates and new code.
- `busy`  out  1: high in SCAN and DONE.
- `frame_done`  out  1: one-cycle pulse at end of pass.
- `diff_count`  out  CW: number of records emitted in the last completed pass.

## Operation
- Code mapping: 0 = BLANK. Flag i maps to code i+1. Lowest set index wins.
- FSM states:
  - IDLE: cursor held at (0,0). `clear` takes priority over `start`; when both are asserted, `clear` is executed and `start` is dropped. `start` latches `force_redraw` into `redraw_q`, zeroes the running count, and moves to SCAN.
  - SCAN: a cell is evaluated on each "step" cycle, where step = `!out_valid || out_ready`. On a step:
    - Compute `new` from `obj_present`.
    - Write `new` into the shadow frame at the cursor.
    - If `new != stored` or `redraw_q`, load the output register with the cursor and `new`, set `out_valid`, and increment the running count.
    - Advance the cursor: x increments; at x = COLS-1, x wraps to 0 and y increments.
    - The step on cell (COLS-1, ROWS-1) goes to DONE.
    - With no step, cursor and frame hold and `obj_present` is ignored.
  - DONE: for one cycle, pulse `frame_done`, copy the running count to `diff_count`, then return to IDLE.
- Output register: `out_valid` clears on `out_ready` when no new record loads the same cycle. A record that loads on an accepting cycle replaces the old one with no bubble.
- `start` and `clear` are ignored in SCAN and DONE.
- Reset, at any time including mid-pass:
  - state IDLE, shadow frame all BLANK, cursor (0,0);
  - `out_valid`, `out_x`, `out_y`, `out_code` = 0;
  - `frame_done` = 0, `diff_count` = 0, `busy` = 0, `redraw_q` = 0.

## Timing
- `start` in cycle t puts the FSM in SCAN at t+1. With `out_ready` held high, the cell with linear index n is evaluated at t+1+n.
- The output record appears one cycle after its cell is evaluated.
- `frame_done` is asserted at t+1+COLS*ROWS when there are no stalls. Each cycle of back-pressure adds one cycle.
- The last record may still be pending when `frame_done` pulses; downstream drains it normally.
- `clear` takes effect on the next edge. Minimum IDLE dwell between passes is 1 cycle.
- `diff_count` updates in the same cycle `frame_done` is high and holds until the next DONE.

## Structure
- `grid_pkg`: default COLS/ROWS, BLANK constant, and `grid_obj_e` code enum for the default config (BLANK, BORDER, HEAD, BODY, APPLE at indices 0..3 → codes 1..4), plus the `scan_state_e` typedef.
- Sub-module `grid_frame_mem`: COLS*ROWS x CODE_W register file with one async-read port, one write port, and synchronous bulk clear; reset to BLANK. The FSM, priority encoder, and output register live in `grid_diff_scanner`.

## Test plan
- Reset, `start` with all flags 0 → no `out_valid`; `frame_done` at t+193; `diff_count` = 0.
- Flag0 set at (0,0) and (15,11) only, `out_ready` = 1 → exactly two records, (0,0,1) then (15,11,1); `diff_count` = 2. Repeating the pass gives `diff_count` = 0.
- Flags 0b1010 at (3,4) → code 2 (priority). Next pass with flags 0 → record (3,4,0).
- `force_redraw` = 1 on an unchanged frame → 192 records in raster order; `diff_count` = 192.
- All cells differ, `out_ready` toggling 1/0 → no record lost or duplicated; the cursor stalls while `out_valid && !out_ready`; `frame_done` is delayed by the stall count.
- `nrst` low mid-pass at cell 50 → outputs at reset values immediately. The following pass reports all non-blank cells as changed. `clear`+`start` in IDLE → cleared, FSM stays IDLE.
